// File: rtl/pwm_update_scheduler_pkg.sv
// Shared types and constants for the PWM update scheduler.
package pwm_sched_pkg;

  localparam int DEF_NUM_CH = 12;

  // Channel group base indices within the generator bank
  localparam int SR_BASE    = 0;
  localparam int SD_BASE    = 4;
  localparam int SERVO_BASE = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_ACK  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/pwm_update_scheduler_if.sv
// Decoder-side and generator-side signals of the PWM update scheduler.
interface pwm_sched_if
  import pwm_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
);
  logic [NUM_CH-1:0]   pwm_update;
  logic [8*NUM_CH-1:0] pwm_target_flat;
  logic [NUM_CH-1:0]   pwm_done;
  logic                ch_load;
  logic [3:0]          ch_sel;
  logic [7:0]          ch_target;
  logic [NUM_CH-1:0]   ch_done;
  logic                busy;
  logic                timeout_err;
  logic [3:0]          err_ch;

  modport master (
    input  pwm_update, pwm_target_flat, ch_done,
    output pwm_done, ch_load, ch_sel, ch_target, busy, timeout_err, err_ch
  );

  modport slave (
    output pwm_update, pwm_target_flat, ch_done,
    input  pwm_done, ch_load, ch_sel, ch_target, busy, timeout_err, err_ch
  );
endinterface

// File: rtl/pwm_update_scheduler_arb.sv
// Combinational rotating-priority picker: first requester after 'last', wrapping.
module rr_arbiter
  import pwm_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [3:0]        last,
  output logic [3:0]        gnt_idx,
  output logic              gnt_valid
);
  localparam int IW = $clog2(NUM_CH);

  int            cand;
  logic [IW-1:0] cand_i;

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    cand_i    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand   = (int'(last) + k) % NUM_CH;
      cand_i = IW'(cand);
      if (!gnt_valid && req[cand_i]) begin
        gnt_valid = 1'b1;
        gnt_idx   = 4'(cand);
      end
    end
  end

endmodule

// File: rtl/pwm_update_scheduler.sv
// Services pending PWM channel updates one at a time, round-robin, with a
// per-channel timeout so a dead generator cannot stall the others.
//
// state  | meaning
// IDLE   | waiting for an eligible channel; grant and capture target
// LOAD   | one-cycle load strobe to the generator bank, clear timer
// WAIT   | wait for ch_done of the granted channel or timeout
// ACK    | one-cycle pwm_done to the decoder, mark channel serviced
module pwm_update_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic         fpga_clock,
  input logic         reset,
  pwm_sched_if.master bus
);
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_RST = 4'(NUM_CH - 1);

  sched_state_t      state, state_nxt;
  logic [3:0]        grant, last_grant, arb_idx, err_ch_q;
  logic              arb_valid, timeout_q;
  logic [NUM_CH-1:0] serviced, eligible, set_mask;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        target_q;
  logic [7:0]        target_arr [NUM_CH];
  logic              do_grant, do_timeout, cnt_clr, cnt_inc, ack;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_tgt
    assign target_arr[i] = bus.pwm_target_flat[8*i +: 8];
  end

  // A channel stays blocked after its ack until the decoder drops the request
  assign eligible = bus.pwm_update & ~serviced;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (eligible),
    .last      (last_grant),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  always_ff @(posedge fpga_clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    do_grant     = 1'b0;
    do_timeout   = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    ack          = 1'b0;
    bus.ch_load  = 1'b0;
    bus.pwm_done = '0;
    case (state)
      S_IDLE: begin
        if (arb_valid) begin
          do_grant  = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        bus.ch_load = 1'b1;
        cnt_clr     = 1'b1;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (bus.ch_done[grant]) begin
          state_nxt = S_ACK;
        end else if (cnt == CNT_LAST) begin
          do_timeout = 1'b1;
          state_nxt  = S_ACK;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_ACK: begin
        ack                 = 1'b1;
        bus.pwm_done[grant] = 1'b1;
        state_nxt           = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    set_mask = '0;
    if (ack) set_mask[grant] = 1'b1;
  end

  always_ff @(posedge fpga_clock) begin
    if (reset) begin
      grant      <= '0;
      last_grant <= LAST_RST;
      target_q   <= '0;
      cnt        <= '0;
      err_ch_q   <= '0;
      timeout_q  <= 1'b0;
      serviced   <= '0;
    end else begin
      timeout_q <= do_timeout;
      // Dropped request clears the mask even in the ack cycle
      serviced  <= (serviced | set_mask) & bus.pwm_update;
      if (do_grant) begin
        grant      <= arb_idx;
        last_grant <= arb_idx;
        target_q   <= target_arr[arb_idx];
      end
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (do_timeout) err_ch_q <= grant;
    end
  end

  assign bus.ch_sel      = grant;
  assign bus.ch_target   = target_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.timeout_err = timeout_q;
  assign bus.err_ch      = err_ch_q;

endmodule
